ifetch_480: RTL and testbench

Instruction-fetch and PC stage directly upstream of ctrl_480.
- Holds the architectural PC and fetches one instruction at a time over a req/gnt/rvalid instruction-memory port.
- Presents the instruction so its Op/Funct3/Funct7 fields feed the control decoder.
- When the core retires the instruction, computes the next PC from the decoder's NPCOp, the ALU Zero flag, the immediate and the ALU result.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/npc_calc_480.sv | 31 +++
 rtl/ifetch_480.sv | 118 +++++++++++
 tb/tb_ifetch_480.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the ifetch_480 fetch/PC stage.
//   NPC_*    : next-PC select encoding, identical to the decoder's NPCOp field
//   NOP_INST : addi x0,x0,0, shown on inst while nothing has been fetched
//   state_e  : fetch FSM states (S_IDLE_TRAP used only with IFETCH_MISALIGN_TRAP_EN)
package ifetch_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JALR = 3'b100;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_IDLE_TRAP
  } state_e;

endpackage

// File: rtl/npc_calc_480.sv
// npc_calc_480: purely combinational next-PC generator.
//   pc, npc_op, zero, imm, alu_result -> next_pc (raw, not yet aligned), pc_plus4
// All sums are modulo 2^ADDR_W; carries out of the top bit are dropped.
module npc_calc_480
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        npc_op,
  input  logic              zero,
  input  logic [31:0]       imm,
  input  logic [31:0]       alu_result,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  assign pc_plus4 = pc + ADDR_W'(4);

  always_comb begin
    next_pc = pc_plus4;
    case (npc_op)
      NPC_BR:   if (zero) next_pc = pc + imm;
      NPC_JAL:  next_pc = pc + imm;
      // jalr clears bit 0 of the target, as the ISA requires
      NPC_JALR: next_pc = alu_result & ~ADDR_W'(1);
      default:  next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifetch_480.sv
// ifetch_480: instruction fetch and PC stage feeding ctrl_480.
//   clk, rstn                : clock (rising edge), async active-low reset
//   imem_req/addr/gnt        : fetch request, held until granted
//   imem_rvalid/rdata        : returned instruction word
//   inst_valid, inst, pc,
//   pc_plus4                 : instruction presented to decode/execute
//   inst_ack                 : core retires inst (only honoured while inst_valid)
//   npc_op, zero, imm,
//   alu_result               : next-PC inputs from decoder/extender/ALU
//   fetch_misalign           : only when IFETCH_MISALIGN_TRAP_EN is defined
// Optional macro IFETCH_MISALIGN_TRAP_EN: a misaligned next PC traps into
// S_IDLE_TRAP instead of being silently aligned down to a word boundary.
module ifetch_480
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              inst_ack,
  input  logic [2:0]        npc_op,
  input  logic              zero,
  input  logic [31:0]       imm,
  input  logic [31:0]       alu_result
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic              fetch_misalign
`endif
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] next_pc, pc_load;
  logic              retire;

  npc_calc_480 #(.ADDR_W(ADDR_W)) u_npc (
    .pc        (pc),
    .npc_op    (npc_op),
    .zero      (zero),
    .imm       (imm),
    .alu_result(alu_result),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4)
  );

  // inst_valid is high exactly in S_HOLD, so gating on state covers
  // "ack without valid is ignored"
  assign retire = (state == S_HOLD) && inst_ack;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = retire && (next_pc[1:0] != 2'b00);
  assign pc_load  = next_pc;
`else
  assign pc_load  = next_pc & ~ADDR_W'(3);
`endif

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ:  if (imem_gnt) state_n = S_WAIT;
      S_WAIT: if (imem_rvalid) state_n = S_HOLD;
      S_HOLD: begin
        if (inst_ack) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          state_n = misalign ? S_IDLE_TRAP : S_REQ;
`else
          state_n = S_REQ;
`endif
        end
      end
      default: state_n = state; // S_IDLE_TRAP: left only by reset
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      if (state == S_WAIT && imem_rvalid) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        pc         <= pc_load;
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         fetch_misalign <= 1'b0;
    else if (misalign) fetch_misalign <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifetch_480.sv
// tb_ifetch_480: randomized bench for ifetch_480 with a behavioural PC model.
module tb_ifetch_480;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ack, zero;
  logic [31:0] inst, pc, pc_plus4, imm, alu_result;
  logic [2:0]  npc_op;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  ifetch_480 #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .inst_ack(inst_ack), .npc_op(npc_op), .zero(zero), .imm(imm),
    .alu_result(alu_result)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, failures = 0;
  logic [31:0] mpc;           // model architectural PC
  int          last_valid_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // next PC straight from the ISA rules (before any alignment handling)
  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [2:0] op,
                                          input logic z, input logic [31:0] im,
                                          input logic [31:0] al);
    case (op)
      3'd1:    return z ? p + im : p + 32'd4;
      3'd2:    return p + im;
      3'd4:    return {al[31:1], 1'b0};
      default: return p + 32'd4;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ack = 0;
    npc_op = '0; zero = 0; imm = '0; alu_result = '0;
    @(negedge clk);
    chk("rst_valid", inst_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0000_0013);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", fetch_misalign, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    mpc = RST_PC;
    last_valid_cyc = cyc;
  endtask

  // Acts as instruction memory: gnt after gd stall cycles, rvalid rd cycles
  // after the earliest legal slot. Stray gnt/rvalid/ack are injected where
  // they must be ignored.
  task automatic fetch(input int gd, input int rd, input logic [31:0] data, output int gap);
    int n = 0;
    gap = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("fetch_addr", imem_addr, mpc);
    repeat (gd) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, mpc);
    end
    imem_rvalid = 0;
    imem_gnt    = 1;
    @(negedge clk);
    imem_gnt = 0;
    chk("req_drop", imem_req, 0);
    repeat (rd) begin
      imem_gnt   = 1'($urandom_range(0, 1));
      inst_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_novalid", inst_valid, 0);
      chk("wait_noreq", imem_req, 0);
    end
    imem_gnt = 0; inst_ack = 0;
    imem_rvalid = 1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 0; imem_rdata = $urandom;
    chk("valid", inst_valid, 1);
    chk("inst", inst, data);
    chk("pc", pc, mpc);
    chk("pc_plus4", pc_plus4, mpc + 32'd4);
    gap = cyc - last_valid_cyc;
    last_valid_cyc = cyc;
  endtask

  task automatic ack(input logic [2:0] op, input logic z, input logic [31:0] im,
                     input logic [31:0] al, input bit wait_first);
    logic [31:0] exp;
    if (wait_first) begin
      repeat ($urandom_range(1, 2)) begin
        @(negedge clk);
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", pc, mpc);
      end
    end
    npc_op = op; zero = z; imm = im; alu_result = al; inst_ack = 1;
    exp = ref_npc(mpc, op, z, im, al);
    @(negedge clk);
    inst_ack = 0;
    npc_op = 3'($urandom); zero = 1'($urandom); imm = $urandom; alu_result = $urandom;
    chk("ack_valid", inst_valid, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (exp[1:0] != 2'b00) begin
      chk("trap_flag", fetch_misalign, 1);
      chk("trap_pc", pc, exp);
      repeat (3) begin
        @(negedge clk);
        chk("trap_req", imem_req, 0);
        chk("trap_valid", inst_valid, 0);
      end
      do_reset();
      return;
    end
    chk("no_trap", fetch_misalign, 0);
    mpc = exp;
`else
    mpc = exp & ~32'd3;
`endif
    chk("npc_req", imem_req, 1);
    chk("npc_addr", imem_addr, mpc);
  endtask

  initial begin
    int gap;
    logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [2:0] op;
    logic [31:0] im;

    do_reset();

    // first fetch at minimum latency
    fetch(0, 0, 32'h0050_0093, gap);
    chk("lat_first", gap, 3);

    // back-to-back sequential: 0, 4, 8 at 3 cycles each
    ack(3'd0, 0, 0, 0, 0);
    fetch(0, 0, $urandom, gap);
    chk("lat_seq4", gap, 3);
    ack(3'd0, 0, 0, 0, 0);
    fetch(0, 0, $urandom, gap);
    chk("lat_seq8", gap, 3);
    chk("pc_is_8", pc, 32'h8);

    // branch taken / not taken from pc=8
    ack(3'd1, 1, 32'hFFFF_FFF8, 0, 1);
    chk("br_taken", imem_addr, 32'h0);
    fetch(0, 0, $urandom, gap);
    ack(3'd0, 0, 0, 0, 1); fetch(0, 0, $urandom, gap);
    ack(3'd0, 0, 0, 0, 1); fetch(0, 0, $urandom, gap);
    ack(3'd1, 0, 32'hFFFF_FFF8, 0, 1);
    chk("br_not_taken", imem_addr, 32'hC);
    fetch(1, 1, $urandom, gap);

    // jal / jalr
    ack(3'd0, 0, 0, 0, 0); fetch(0, 0, $urandom, gap);
    chk("pc_is_10", pc, 32'h10);
    ack(3'd2, 0, 32'h100, 0, 1);
    chk("jal", imem_addr, 32'h110);
    fetch(0, 0, $urandom, gap);
    ack(3'd4, 0, 0, 32'h203, 1);
    fetch(0, 0, $urandom, gap);

    // wrap-around of pc+4
    ack(3'd4, 0, 0, 32'hFFFF_FFFC, 0);
    chk("jalr_top", imem_addr, 32'hFFFF_FFFC);
    fetch(0, 0, $urandom, gap);
    ack(3'd0, 0, 0, 0, 0);
    chk("wrap", imem_addr, 32'h0);

    // stalled grant and late data
    fetch(4, 2, $urandom, gap);
    ack(3'd0, 0, 0, 0, 0);

    // reset while waiting for data, then a stray rvalid
    gap = 0;
    while (!imem_req && gap < 10) begin @(negedge clk); gap++; end
    chk("abort_req", imem_req, 1);
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    rstn = 0;
    #1;
    chk("abort_req0", imem_req, 0);
    chk("abort_pc", pc, RST_PC);
    chk("abort_valid", inst_valid, 0);
    @(negedge clk);
    rstn = 1; mpc = RST_PC; last_valid_cyc = cyc;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 0;
    chk("stray_valid", inst_valid, 0);
    chk("stray_inst", inst, 32'h0000_0013);
    fetch(0, 0, 32'h1234_5678, gap);

    // misaligned jalr target
    ack(3'd4, 0, 0, 32'h206, 1);
    fetch(0, 0, $urandom, gap);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 7)];
      im = ($urandom_range(0, 3) == 0) ? $urandom
                                        : 32'($signed(32'($urandom_range(0, 63)) - 32) * 4);
      ack(op, 1'($urandom), im, $urandom, 1'($urandom));
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, gap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog");
  end

endmodule
